text_cursor_writer: RTL and testbench

- Write-side initiator for the character text buffer: accepts a stream of 8-bit character codes and keeps an internal cursor (x, y).
- Printable codes become single-cell writes on the buffer's write port (write_enable / write_x / write_y / write_data / write_color / write_lang, flow-controlled by busy).
- Control codes move the cursor or clear the screen.
- Sits between a UART/keyboard character source and the text buffer feeding the VGA text renderer.

---
 rtl/text_cursor_writer_pkg.sv | 31 +++
 rtl/text_write_port.sv | 85 ++++++++
 rtl/text_cursor_writer.sv | 233 +++++++++++++++++++++++
 tb/tb_text_cursor_writer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_cursor_writer_pkg.sv
// Shared types and constants for the text cursor writer.
// Widths, character codes and FSM states.
package text_pkg;

  localparam int COLS_DEF = 80;
  localparam int ROWS_DEF = 30;
  localparam int X_W      = 7;
  localparam int Y_W      = 5;

  localparam logic [7:0] CH_SPACE     = 8'h20;
  localparam logic [7:0] CH_BS        = 8'h08;
  localparam logic [7:0] CH_LF        = 8'h0A;
  localparam logic [7:0] CH_CR        = 8'h0D;
  localparam logic [7:0] CH_FF        = 8'h0C;
  localparam logic [7:0] CH_PRINT_MIN = 8'h20;
  localparam logic [7:0] CH_PRINT_MAX = 8'h7E;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    CLEAR
  } state_e;

  function automatic logic is_print(input logic [7:0] c);
    return (c >= CH_PRINT_MIN) && (c <= CH_PRINT_MAX);
  endfunction

endpackage

// File: rtl/text_write_port.sv
// Single-cell write sequencer toward the text buffer.
// Holds address/data from start until busy drops again.
module text_write_port
  import text_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [X_W-1:0] x_i,
  input  logic [Y_W-1:0] y_i,
  input  logic [6:0]     data_i,
  input  logic [11:0]    color_i,
  input  logic           lang_i,
  input  logic           busy_i,
  output logic           done_o,
  output logic           we_o,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic [6:0]     data_o,
  output logic [11:0]    color_o,
  output logic           lang_o
);

  state_e         st_q;
  logic           we_q;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic [6:0]     data_q;
  logic [11:0]    color_q;
  logic           lang_q;

  // Request/acknowledge sequence; write_enable pulses once per start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      we_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      data_q  <= '0;
      color_q <= '0;
      lang_q  <= 1'b0;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (start_i) begin
            x_q     <= x_i;
            y_q     <= y_i;
            data_q  <= data_i;
            color_q <= color_i;
            lang_q  <= lang_i;
            we_q    <= !busy_i;
            st_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (we_q) begin
            we_q <= 1'b0;
            st_q <= WAIT_HI;
          end else if (!busy_i) begin
            we_q <= 1'b1;
          end
        end
        WAIT_HI: begin
          if (busy_i) st_q <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!busy_i) st_q <= IDLE;
        end
        default: begin
          we_q <= 1'b0;
          st_q <= IDLE;
        end
      endcase
    end
  end

  assign done_o  = (st_q == WAIT_LO) && !busy_i;
  assign we_o    = we_q;
  assign x_o     = x_q;
  assign y_o     = y_q;
  assign data_o  = data_q;
  assign color_o = color_q;
  assign lang_o  = lang_q;

endmodule

// File: rtl/text_cursor_writer.sv
// Character stream to text-buffer writer with cursor tracking.
// Optional AUTO_CLEAR_LINE_EN blanks each row the cursor enters.
module text_cursor_writer
  import text_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           char_valid,
  input  logic [7:0]     char_data,
  output logic           char_ready,
  input  logic [11:0]    color,
  input  logic           lang,
  output logic           write_enable,
  output logic [X_W-1:0] write_x,
  output logic [Y_W-1:0] write_y,
  output logic [6:0]     write_data,
  output logic [11:0]    write_color,
  output logic           write_lang,
  input  logic           busy,
  output logic [X_W-1:0] cursor_x,
  output logic [Y_W-1:0] cursor_y
);

  localparam logic [X_W-1:0] XMAX = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] YMAX = Y_W'(ROWS - 1);
  localparam logic [6:0]     SP7  = CH_SPACE[6:0];

  logic [1:0]     rs_q;
  logic           rst_n;
  state_e         st_q;
  logic           rdy_q;
  logic [7:0]     ch_q;
  logic [11:0]    col_q;
  logic           lang_q;
  logic [X_W-1:0] cx_q, px_q, rx_q;
  logic [Y_W-1:0] cy_q, py_q, ry_q;
  logic [6:0]     rd_q;
  logic           start_q;
  logic           full_q;
`ifdef AUTO_CLEAR_LINE_EN
  logic           wrap_q;
`endif
  logic           done;
  logic [Y_W-1:0] lf_y;
  logic [X_W-1:0] adv_x, bs_x;
  logic [Y_W-1:0] adv_y, bs_y;
  logic           clr_last;

  // Async assert, sync release of the internal reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rs_q <= 2'b00;
    else          rs_q <= {rs_q[0], 1'b1};
  end
  assign rst_n = rs_q[1];

  assign lf_y  = (cy_q == YMAX) ? '0 : cy_q + 1'b1;
  assign adv_x = (cx_q == XMAX) ? '0 : cx_q + 1'b1;
  assign adv_y = (cx_q == XMAX) ? lf_y : cy_q;
  assign bs_x  = (cx_q != '0) ? cx_q - 1'b1 :
                 (cy_q != '0) ? XMAX : '0;
  assign bs_y  = (cx_q != '0) ? cy_q :
                 (cy_q != '0) ? cy_q - 1'b1 : '0;
  assign clr_last = (rx_q == XMAX) && (!full_q || ry_q == YMAX);

  // Accept, decode and cursor/clear sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      rdy_q   <= 1'b0;
      ch_q    <= '0;
      col_q   <= '0;
      lang_q  <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
      px_q    <= '0;
      py_q    <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      rd_q    <= '0;
      start_q <= 1'b0;
      full_q  <= 1'b0;
`ifdef AUTO_CLEAR_LINE_EN
      wrap_q  <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      unique case (st_q)
        IDLE: begin
          if (char_valid && rdy_q) begin
            ch_q   <= char_data;
            col_q  <= color;
            lang_q <= lang;
            rdy_q  <= 1'b0;
            st_q   <= DECODE;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        DECODE: begin
          unique case (1'b1)
            is_print(ch_q): begin
              rx_q    <= cx_q;
              ry_q    <= cy_q;
              rd_q    <= ch_q[6:0];
              px_q    <= adv_x;
              py_q    <= adv_y;
`ifdef AUTO_CLEAR_LINE_EN
              wrap_q  <= (cx_q == XMAX);
`endif
              start_q <= 1'b1;
              st_q    <= ISSUE;
            end
            (ch_q == CH_BS): begin
              rx_q    <= bs_x;
              ry_q    <= bs_y;
              rd_q    <= SP7;
              px_q    <= bs_x;
              py_q    <= bs_y;
`ifdef AUTO_CLEAR_LINE_EN
              wrap_q  <= 1'b0;
`endif
              start_q <= 1'b1;
              st_q    <= ISSUE;
            end
            (ch_q == CH_CR): begin
              cx_q  <= '0;
              rdy_q <= 1'b1;
              st_q  <= IDLE;
            end
            (ch_q == CH_LF): begin
              cx_q <= '0;
              cy_q <= lf_y;
`ifdef AUTO_CLEAR_LINE_EN
              rx_q    <= '0;
              ry_q    <= lf_y;
              rd_q    <= SP7;
              full_q  <= 1'b0;
              start_q <= 1'b1;
              st_q    <= CLEAR;
`else
              rdy_q <= 1'b1;
              st_q  <= IDLE;
`endif
            end
            (ch_q == CH_FF): begin
              rx_q    <= '0;
              ry_q    <= '0;
              rd_q    <= SP7;
              full_q  <= 1'b1;
              start_q <= 1'b1;
              st_q    <= CLEAR;
            end
            default: begin
              rdy_q <= 1'b1;
              st_q  <= IDLE;
            end
          endcase
        end
        ISSUE: begin
          if (done) begin
            cx_q <= px_q;
            cy_q <= py_q;
`ifdef AUTO_CLEAR_LINE_EN
            if (wrap_q) begin
              rx_q    <= '0;
              ry_q    <= py_q;
              rd_q    <= SP7;
              full_q  <= 1'b0;
              start_q <= 1'b1;
              st_q    <= CLEAR;
            end else begin
              rdy_q <= 1'b1;
              st_q  <= IDLE;
            end
`else
            rdy_q <= 1'b1;
            st_q  <= IDLE;
`endif
          end
        end
        CLEAR: begin
          if (done) begin
            if (clr_last) begin
              cx_q  <= '0;
              if (full_q) cy_q <= '0;
              rdy_q <= 1'b1;
              st_q  <= IDLE;
            end else begin
              if (rx_q == XMAX) begin
                rx_q <= '0;
                ry_q <= ry_q + 1'b1;
              end else begin
                rx_q <= rx_q + 1'b1;
              end
              start_q <= 1'b1;
            end
          end
        end
        default: begin
          rdy_q <= 1'b0;
          st_q  <= IDLE;
        end
      endcase
    end
  end

  text_write_port u_port (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_q),
    .x_i     (rx_q),
    .y_i     (ry_q),
    .data_i  (rd_q),
    .color_i (col_q),
    .lang_i  (lang_q),
    .busy_i  (busy),
    .done_o  (done),
    .we_o    (write_enable),
    .x_o     (write_x),
    .y_o     (write_y),
    .data_o  (write_data),
    .color_o (write_color),
    .lang_o  (write_lang)
  );

  assign char_ready = rdy_q;
  assign cursor_x   = cx_q;
  assign cursor_y   = cy_q;

endmodule

// File: tb/tb_text_cursor_writer.sv
// Directed bench for text_cursor_writer with a simple buffer model.
// Expectations follow AUTO_CLEAR_LINE_EN when it is defined.
module tb_text_cursor_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = '0;
  logic        char_ready;
  logic [11:0] color = '0;
  logic        lang = 1'b0;
  logic        write_enable;
  logic [6:0]  write_x;
  logic [4:0]  write_y;
  logic [6:0]  write_data;
  logic [11:0] write_color;
  logic        write_lang;
  logic        busy = 1'b0;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;

  int checks = 0;
  int errors = 0;

  int          wr_cnt = 0;
  int          sp_f00 = 0;
  int          we_long = 0;
  int          stab_err = 0;
  int          rdy_wr = 0;
  int          bcnt = 0;
  logic        prev_we = 1'b0;
  logic [6:0]  lx = '0;
  logic [4:0]  ly = '0;
  logic [6:0]  ld = '0;
  logic [11:0] lc = '0;
  logic        ll = 1'b0;

  text_cursor_writer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .char_valid   (char_valid),
    .char_data    (char_data),
    .char_ready   (char_ready),
    .color        (color),
    .lang         (lang),
    .write_enable (write_enable),
    .write_x      (write_x),
    .write_y      (write_y),
    .write_data   (write_data),
    .write_color  (write_color),
    .write_lang   (write_lang),
    .busy         (busy),
    .cursor_x     (cursor_x),
    .cursor_y     (cursor_y)
  );

  always #5 clk = ~clk;

  // Buffer model: busy high 2 cycles after a request, for 2 cycles.
  always @(negedge clk) begin
    if (busy && ((write_x !== lx) || (write_y !== ly) ||
        (write_data !== ld) || (write_color !== lc) ||
        (write_lang !== ll)))
      stab_err++;
    if (write_enable) begin
      wr_cnt++;
      lx = write_x;
      ly = write_y;
      ld = write_data;
      lc = write_color;
      ll = write_lang;
      if (prev_we) we_long++;
      if (char_ready) rdy_wr++;
      if (write_data == 7'h20 && write_color == 12'hF00) sp_f00++;
    end
    prev_we = write_enable;
    if (write_enable) bcnt = 1;
    else if (bcnt != 0) bcnt = (bcnt == 3) ? 0 : bcnt + 1;
    busy = (bcnt == 2) || (bcnt == 3);
  end

  task automatic wait_ready(input int lim, input string nm);
    int n;
    n = 0;
    while (!char_ready && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!char_ready) begin
      checks++;
      errors++;
      $display("FAIL %s: char_ready=%0b after %0d cycles, required 1",
               nm, char_ready, lim);
    end
  endtask

  task automatic send(input logic [7:0] c);
    wait_ready(100, "send_pre");
    char_data  = c;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    wait_ready(40000, "send_done");
  endtask

  task automatic chk_cur(input string nm, input int ex, input int ey);
    checks++;
    if (cursor_x !== 7'(ex) || cursor_y !== 5'(ey)) begin
      errors++;
      $display("FAIL %s: cursor=(%0d,%0d) required (%0d,%0d)",
               nm, cursor_x, cursor_y, ex, ey);
    end
  endtask

  task automatic chk_last(input string nm, input int ex, input int ey,
                          input logic [6:0] ed);
    checks++;
    if (lx !== 7'(ex) || ly !== 5'(ey) || ld !== ed) begin
      errors++;
      $display("FAIL %s: last write=(%0d,%0d,%h) required (%0d,%0d,%h)",
               nm, lx, ly, ld, ex, ey, ed);
    end
  endtask

  task automatic chk_cnt(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: count=%0d required %0d", nm, got, exp);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (char_ready !== 1'b0 || write_enable !== 1'b0 ||
        write_x !== '0 || write_data !== '0 || write_color !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b we=%b x=%0d d=%h c=%h required 0",
               char_ready, write_enable, write_x, write_data, write_color);
    end
    chk_cur("reset_cursor", 0, 0);
    reset_n = 1'b1;
    wait_ready(4, "reset_release");
    checks++;
    if (char_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: char_ready=%b required 1", char_ready);
    end
  endtask

  task automatic test_hi;
    int w0;
    w0 = wr_cnt;
    color = 12'h0F0;
    lang = 1'b1;
    send(8'h48);
    chk_cnt("hi_H_cnt", wr_cnt - w0, 1);
    chk_last("hi_H", 0, 0, 7'h48);
    checks++;
    if (lc !== 12'h0F0 || ll !== 1'b1) begin
      errors++;
      $display("FAIL hi_color: color=%h lang=%b required 0f0 1", lc, ll);
    end
    lang = 1'b0;
    send(8'h69);
    chk_last("hi_i", 1, 0, 7'h69);
    chk_cur("hi_cursor", 2, 0);
    chk_cnt("hi_we_len", we_long, 0);
    chk_cnt("hi_stable", stab_err, 0);
  endtask

  task automatic test_wrap;
    int w0;
    for (int i = 0; i < 77; i++) send(8'h78);
    chk_cur("wrap_pre", 79, 0);
    w0 = wr_cnt;
    send(8'h41);
`ifdef AUTO_CLEAR_LINE_EN
    chk_cnt("wrap_cnt", wr_cnt - w0, 81);
    chk_last("wrap_A", 79, 1, 7'h20);
`else
    chk_cnt("wrap_cnt", wr_cnt - w0, 1);
    chk_last("wrap_A", 79, 0, 7'h41);
`endif
    chk_cur("wrap_cursor", 0, 1);
  endtask

  task automatic test_bs;
    int w0;
    w0 = wr_cnt;
    send(8'h08);
    chk_cnt("bs_cnt", wr_cnt - w0, 1);
    chk_last("bs_up", 79, 0, 7'h20);
    chk_cur("bs_up_cursor", 79, 0);
  endtask

  task automatic test_ff;
    int w0, s0, r0;
    w0 = wr_cnt;
    s0 = sp_f00;
    r0 = rdy_wr;
    color = 12'hF00;
    send(8'h0C);
    chk_cnt("ff_cnt", wr_cnt - w0, 2400);
    chk_cnt("ff_space_f00", sp_f00 - s0, 2400);
    chk_last("ff_last", 79, 29, 7'h20);
    chk_cur("ff_cursor", 0, 0);
    chk_cnt("ff_ready_low", rdy_wr - r0, 0);
    chk_cnt("ff_stable", stab_err, 0);
    w0 = wr_cnt;
    send(8'h08);
    chk_cnt("bs00_cnt", wr_cnt - w0, 1);
    chk_last("bs00", 0, 0, 7'h20);
    chk_cur("bs00_cursor", 0, 0);
  endtask

  task automatic test_row_wrap;
    for (int i = 0; i < 29; i++) send(8'h0A);
    chk_cur("rw_lf", 0, 29);
    for (int i = 0; i < 79; i++) send(8'h79);
    chk_cur("rw_pre", 79, 29);
    send(8'h42);
`ifdef AUTO_CLEAR_LINE_EN
    chk_last("rw_B", 79, 0, 7'h20);
`else
    chk_last("rw_B", 79, 29, 7'h42);
`endif
    chk_cur("rw_cursor", 0, 0);
  endtask

  task automatic test_control;
    int w0;
    for (int i = 0; i < 3; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h7A);
    chk_cur("ctl_pre", 5, 3);
    w0 = wr_cnt;
    send(8'h0D);
    chk_cur("ctl_cr", 0, 3);
    chk_cnt("ctl_cr_cnt", wr_cnt - w0, 0);
    send(8'h0A);
    chk_cur("ctl_lf", 0, 4);
`ifdef AUTO_CLEAR_LINE_EN
    chk_cnt("ctl_lf_cnt", wr_cnt - w0, 80);
    chk_last("ctl_lf_last", 79, 4, 7'h20);
`else
    chk_cnt("ctl_lf_cnt", wr_cnt - w0, 0);
`endif
    w0 = wr_cnt;
    send(8'h07);
    send(8'h80);
    chk_cur("ctl_ign", 0, 4);
    chk_cnt("ctl_ign_cnt", wr_cnt - w0, 0);
  endtask

  task automatic test_reset_mid_clear;
    int n, t;
    wait_ready(100, "mid_pre");
    char_data  = 8'h0C;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    n = 0;
    t = 0;
    while (n < 100 && t < 5000) begin
      if (write_enable) n++;
      if (n < 100) begin
        @(negedge clk);
        t++;
      end
    end
    checks++;
    if (n != 100) begin
      errors++;
      $display("FAIL mid_reach: writes=%0d required 100", n);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (write_enable !== 1'b0 || char_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_abort: we=%b rdy=%b required 0 0",
               write_enable, char_ready);
    end
    chk_cur("mid_cursor", 0, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_ready(6, "mid_release");
    checks++;
    if (char_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_ready: char_ready=%b required 1", char_ready);
    end
    color = 12'h00F;
    send(8'h51);
    chk_last("mid_Q", 0, 0, 7'h51);
    checks++;
    if (lc !== 12'h00F) begin
      errors++;
      $display("FAIL mid_color: color=%h required 00f", lc);
    end
    chk_cur("mid_Q_cursor", 1, 0);
  endtask

  initial begin
    test_reset();
    test_hi();
    test_wrap();
    test_bs();
    test_ff();
    test_row_wrap();
    test_control();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
